// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared constants and types for the architectural register file.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t C_ZERO_ADDR = ADDR_W'(ZERO_REG);

endpackage

`default_nettype wire

// File: rtl/decoder5_32.sv
// ============================================================================
// Module  : decoder5_32
// Brief   : Enable-qualified 5:32 one-hot address decoder.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder5_32
    import regfile_pkg::*;
(
    input  logic                i_en,
    input  reg_addr_t           i_addr,
    output logic [NUM_REGS-1:0] o_onehot
);

    // Enable is ANDed per bit so an unknown address with i_en=0 still decodes to 0.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bits
        localparam reg_addr_t c_idx = ADDR_W'(i);
        assign o_onehot[i] = i_en & (i_addr == c_idx);
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wr_decode.sv
// ============================================================================
// Module  : regfile_wr_decode
// Brief   : 32x64 register file, two combinational read ports, one decoded
//           write port; X31 reads as zero. Optional macro
//           REGFILE_WRITE_BYPASS_EN adds write-first forwarding to the reads.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_decode
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reg_write,
    input  reg_addr_t           wr_addr,
    input  reg_data_t           wr_data,
    input  reg_addr_t           rd_addr1,
    input  reg_addr_t           rd_addr2,
    output reg_data_t           rd_data1,
    output reg_data_t           rd_data2,
    output logic [NUM_REGS-1:0] wr_onehot
);

    logic [NUM_REGS-1:0] w_dec_onehot;
    reg_data_t           r_regs [NUM_REGS];

    decoder5_32 u_wr_dec (
        .i_en     (reg_write),
        .i_addr   (wr_addr),
        .o_onehot (w_dec_onehot)
    );

    always_comb begin
        wr_onehot           = w_dec_onehot;
        wr_onehot[ZERO_REG] = 1'b0;
    end

    // The zero register's enable is masked above, so its flop never leaves reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_onehot[i]) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data1 = (rd_addr1 == C_ZERO_ADDR) ? '0 : r_regs[rd_addr1];
        rd_data2 = (rd_addr2 == C_ZERO_ADDR) ? '0 : r_regs[rd_addr2];
`ifdef REGFILE_WRITE_BYPASS_EN
        // wr_onehot already excludes X31, so indexing it by the read address
        // gives the address-match-and-not-zero condition directly.
        if (rst_n && wr_onehot[rd_addr1]) begin
            rd_data1 = wr_data;
        end
        if (rst_n && wr_onehot[rd_addr2]) begin
            rd_data2 = wr_data;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_decode.sv
// ============================================================================
// Module  : tb_regfile_wr_decode
// Brief   : Scoreboard bench for regfile_wr_decode with directed vectors.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wr_decode;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [63:0] rd_data1;
    logic [63:0] rd_data2;
    logic [31:0] wr_onehot;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_wr_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_write (reg_write),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .wr_onehot (wr_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: everything queued since the last posedge is checked at negedge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = sb_q.pop_front();
            case (e.sel)
                0:       act = rd_data1;
                1:       act = rd_data2;
                default: act = {32'h0, wr_onehot};
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: actual=%h required=%h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_out(input int sel, input logic [63:0] v, input string n);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        reg_write = 1'b1;
        wr_addr   = 5'd4;
        wr_data   = 64'h55;
        rd_addr1  = 5'd4;
        rd_addr2  = 5'd0;

        // Reset state; the decoder is not gated by reset.
        cyc();
        expect_out(0, 64'h0, "reset_rd1");
        expect_out(1, 64'h0, "reset_rd2");
        expect_out(2, 64'h10, "reset_onehot");

        cyc();
        rst_n     = 1'b1;
        reg_write = 1'b0;
        expect_out(0, 64'h0, "post_reset_x4");

        // Write X5, then pulse reset between edges.
        cyc();
        reg_write = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 64'hDEAD_BEEF;
        rd_addr1  = 5'd5;
        expect_out(2, 64'h20, "onehot_x5");
`ifdef REGFILE_WRITE_BYPASS_EN
        expect_out(0, 64'hDEAD_BEEF, "bypass_x5");
`else
        expect_out(0, 64'h0, "old_x5");
`endif
        cyc();
        reg_write = 1'b0;
        expect_out(0, 64'hDEAD_BEEF, "wrote_x5");

        cyc();
        rst_n     = 1'b0;
        reg_write = 1'b1;
        wr_addr   = 5'd6;
        wr_data   = 64'h77;
        rd_addr2  = 5'd6;
        #1;
        n_checks++;
        if (rd_data1 !== 64'h0) begin
            n_fail++;
            $display("FAIL async_clear_x5_immediate: actual=%h required=%h", rd_data1, 64'h0);
        end
        expect_out(0, 64'h0, "async_clear_x5");
        expect_out(1, 64'h0, "no_bypass_in_reset");

        cyc();
        rst_n     = 1'b1;
        reg_write = 1'b0;
        expect_out(0, 64'h0, "after_release_x5");
        expect_out(1, 64'h0, "no_write_in_reset_x6");

        // Basic writes.
        cyc();
        reg_write = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 64'd64357;
        #1;
        n_checks++;
        if (wr_onehot !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL onehot_x3_immediate: actual=%h required=%h", wr_onehot, 32'h0000_0008);
        end
        expect_out(2, 64'h8, "onehot_x3");
        cyc();
        wr_addr = 5'd7;
        wr_data = 64'd26000;
        expect_out(2, 64'h80, "onehot_x7");
        cyc();
        reg_write = 1'b0;
        rd_addr1  = 5'd3;
        rd_addr2  = 5'd7;
        #1;
        n_checks++;
        if (rd_data1 !== 64'd64357) begin
            n_fail++;
            $display("FAIL read_x3_immediate: actual=%h required=%h", rd_data1, 64'd64357);
        end
        n_checks++;
        if (rd_data2 !== 64'd26000) begin
            n_fail++;
            $display("FAIL read_x7_immediate: actual=%h required=%h", rd_data2, 64'd26000);
        end
        expect_out(0, 64'd64357, "read_x3");
        expect_out(1, 64'd26000, "read_x7");

        // Zero register write is dropped.
        cyc();
        reg_write = 1'b1;
        wr_addr   = 5'd31;
        wr_data   = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_addr1  = 5'd31;
        expect_out(2, 64'h0, "onehot_x31");
        expect_out(0, 64'h0, "x31_same_cycle");
        cyc();
        reg_write = 1'b0;
        rd_addr2  = 5'd3;
        expect_out(0, 64'h0, "x31_after");
        expect_out(1, 64'd64357, "x3_kept_after_x31");
        cyc();
        rd_addr2 = 5'd7;
        expect_out(1, 64'd26000, "x7_kept_after_x31");

        // Write disabled.
        cyc();
        reg_write = 1'b0;
        wr_addr   = 5'd3;
        wr_data   = 64'h1234;
        rd_addr1  = 5'd3;
        expect_out(2, 64'h0, "onehot_disabled");
        expect_out(0, 64'd64357, "x3_disabled_now");
        cyc();
        expect_out(0, 64'd64357, "x3_disabled_after");

        // Same-cycle read/write of X9.
        cyc();
        reg_write = 1'b1;
        wr_addr   = 5'd9;
        wr_data   = 64'hA;
        cyc();
        wr_data  = 64'hB;
        rd_addr1 = 5'd9;
        rd_addr2 = 5'd9;
`ifdef REGFILE_WRITE_BYPASS_EN
        expect_out(0, 64'hB, "x9_rd1_before");
        expect_out(1, 64'hB, "x9_rd2_before");
`else
        expect_out(0, 64'hA, "x9_rd1_before");
        expect_out(1, 64'hA, "x9_rd2_before");
`endif
        cyc();
        reg_write = 1'b0;
        expect_out(0, 64'hB, "x9_rd1_after");
        expect_out(1, 64'hB, "x9_rd2_after");

        // Sweep every register.
        for (int i = 0; i < 31; i++) begin
            cyc();
            reg_write = 1'b1;
            wr_addr   = 5'(i);
            wr_data   = 64'(i) * 64'h0101;
            expect_out(2, 64'h1 << i, $sformatf("sweep_onehot_%0d", i));
        end
        cyc();
        reg_write = 1'b0;
        for (int a = 0; a < 32; a++) begin
            logic [63:0] e1;
            logic [63:0] e2;
            e1 = (a == 31) ? 64'h0 : 64'(a) * 64'h0101;
            e2 = (a == 0) ? 64'h0 : 64'(31 - a) * 64'h0101;
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            expect_out(0, e1, $sformatf("sweep_rd1_%0d", a));
            expect_out(1, e2, $sformatf("sweep_rd2_%0d", 31 - a));
            cyc();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        if (n_fail == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL summary: actual=%0d failures required=0", n_fail);
        end
        $finish;
    end

endmodule

`default_nettype wire
